fb_pingpong_arbiter: RTL and testbench
======================================

# fb_pingpong_arbiter

Sequences the two single-port 1-bit frame-buffer BRAMs (bram0/bram1) of the HDMI path as a ping-pong pair. One buffer is the display buffer, read by the pixel scanner. The other is the draw buffer: it is first cleared by an internal engine, then written by the trace plotter. The buffers swap only at a frame boundary, and only after the plotter has finished a complete trace, so the display never shows a partly drawn or partly cleared frame. The block sits between the plotter/scanner logic of hdmiController and the two BRAM instances.

## Interface
- ADDR_WIDTH, 19, BRAM address width
- DEPTH, 524288, used locations per buffer (WIDTH*HEIGHT); must satisfy DEPTH ≤ 2^ADDR_WIDTH

- clkRD  in  1  system clock; the BRAMs are clocked on ~clkRD
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each display frame (vertical sync)
- wr_req  in  1  plotter write request
- wr_addr  in  ADDR_WIDTH  plotter write address
- wr_data  in  1  plotter pixel bit
- wr_last  in  1  marks the final write of the trace; qualified by an accepted write
- wr_ready  out  1  draw buffer is accepting writes
- rd_en  in  1  scanner read request
- rd_addr  in  ADDR_WIDTH  scanner read address
- rd_data  out  1  read pixel
- rd_valid  out  1  rd_data is valid
- EN0, WE0  out  1  bram0 enable and write enable
- addrB0  out  ADDR_WIDTH  bram0 address
- EN1, WE1  out  1  bram1 enable and write enable
- addrB1  out  ADDR_WIDTH  bram1 address
- WD  out  1  write data, shared by both BRAMs
- RD0, RD1  in  1  BRAM read data
- disp_sel  out  1  index of the current display buffer
- frame_valid  out  1  at least one swap has occurred since reset
- addr_err  out  1  sticky flag: a write was dropped because wr_addr ≥ DEPTH

## Operation
- The draw buffer is always the opposite of disp_sel (~disp_sel).
- Draw FSM states: CLEAR, DRAW, DONE.
- CLEAR
  - A clear counter runs from 0 to DEPTH-1, one location per cycle.
  - Each cycle writes WD=0 to the draw buffer; wr_ready=0.
  - At count DEPTH-1 the FSM moves to DRAW.
- DRAW
  - wr_ready=1.
  - A write is accepted on any cycle where wr_req=1.
  - If wr_addr < DEPTH, the draw buffer's EN=1, WE=1, addr=wr_addr and WD=wr_data.
  - If wr_addr ≥ DEPTH, the write is dropped and addr_err is set.
  - An accepted write with wr_last=1 moves the FSM to DONE. This applies even if the write itself was dropped.
- DONE
  - wr_ready=0 and the draw port is idle.
  - On frame_start: disp_sel toggles, frame_valid is set, and the FSM returns to CLEAR. The clear counter restarts at 0 on the newly assigned draw buffer.
- frame_start while in CLEAR or DRAW is ignored. The display keeps showing the old frame.
- wr_last and frame_start in the same cycle: the FSM enters DONE and no swap happens. The swap occurs at the next frame_start.
- Display port
  - The display buffer's EN=rd_en, WE=0, addr=rd_addr.
  - rd_data = RD of the display buffer, forced to 0 while frame_valid=0.
- The two BRAM ports are never shared within a cycle. The draw port belongs to the clear engine or the plotter, depending on FSM state; the display port belongs to the scanner only.

## Timing
- Reset values
  - State CLEAR, clear counter 0, disp_sel=0 (so the draw buffer is bram1).
  - frame_valid=0, addr_err=0, rd_valid=0, rd_data=0.
  - On entry to CLEAR from reset, wr_ready=0.
- BRAM control outputs (EN*, WE*, addrB*, WD) are combinational from the current state and inputs. The BRAM captures them on the falling edge of the same cycle.
- Read latency: rd_en in cycle N produces rd_valid=1 and rd_data at cycle N+1.
  - The display buffer is selected by the disp_sel value registered at cycle N.
  - A read issued in the same cycle as a frame_start that causes a swap uses the old buffer.
- disp_sel changes on the clock edge that samples frame_start; the first read on the new buffer is at N+1.
- A clear lasts exactly DEPTH cycles. wr_ready rises on cycle DEPTH after CLEAR entry.
- Asserting rst_n mid-clear or mid-draw drops all EN*/WE* to 0 immediately. The clear restarts after reset is released.

## Structure
- A shared package holds:
  - the FSM state enum (CLEAR, DRAW, DONE);
  - constants for buffer indices 0/1;
  - the ADDR_WIDTH default shared with hdmiController.
- One sub-module, fb_clear_engine: counter, start/busy/done signalling, address output. The port mux and FSM stay in the top module.

## Test plan
- Reset with DEPTH=16 → WE1=1 at addrB1=0..15 over 16 cycles with WD=0; wr_ready rises on cycle 16; EN0=0 throughout.
- In DRAW, write addrs 3, 7, 15 with data 1, the last with wr_last → bram1 holds 1s at those addrs; frame_start → disp_sel=1, frame_valid=1, and bram0 clear begins.
- frame_start during DRAW → no toggle of disp_sel; a later wr_last followed by frame_start → swap.
- wr_last and frame_start in the same cycle → no swap that frame; swap on the next frame_start.
- After a swap, reading addr 7 → rd_data=1 at N+1; reading addr 8 → 0; reading while frame_valid=0 → rd_data=0.
- Write to addr 20 with DEPTH=16 → no WE pulse and addr_err=1 (sticky); rst_n low mid-clear → EN*/WE* go to 0 at once and the clear restarts from 0.

Source files
------------

// File: rtl/fb_pingpong_arbiter_pkg.sv
// Shared definitions for the ping-pong frame-buffer arbiter and its clear engine.
// FB_ADDR_WIDTH matches the BRAM address width used by hdmiController.
package fb_pingpong_arbiter_pkg;

    localparam int FB_ADDR_WIDTH = 19;

    localparam logic BUF0 = 1'b0;
    localparam logic BUF1 = 1'b1;

    typedef enum logic [1:0] {
        CLEAR,
        DRAW,
        DONE
    } draw_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Sweeps a counter over every used buffer location, one per cycle, to blank the draw buffer.
// Comes out of reset busy so the first draw buffer is cleared without an explicit start.
module fb_clear_engine
    import fb_pingpong_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DEPTH      = 524288
) (
    input  logic                  clkRD,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] count;
    logic                  busy_q;

    // The counter parks at 0 when idle so a restart always begins at location 0.
    always_ff @(posedge clkRD or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            busy_q <= 1'b1;
        end else if (start) begin
            count  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (count == LAST) begin
                count  <= '0;
                busy_q <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (count == LAST);
    assign addr = count;

endmodule

// File: rtl/fb_pingpong_arbiter.sv
// Ping-pong sequencing of two 1-bit frame-buffer BRAMs: clear, draw, then swap on a frame boundary.
// BRAM controls are combinational; the BRAMs sample them on the falling clock edge.
module fb_pingpong_arbiter
    import fb_pingpong_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DEPTH      = 524288
) (
    input  logic                  clkRD,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    input  logic                  wr_last,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  rd_valid,
    output logic                  EN0,
    output logic                  WE0,
    output logic [ADDR_WIDTH-1:0] addrB0,
    output logic                  EN1,
    output logic                  WE1,
    output logic [ADDR_WIDTH-1:0] addrB1,
    output logic                  WD,
    input  logic                  RD0,
    input  logic                  RD1,
    output logic                  disp_sel,
    output logic                  frame_valid,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    draw_state_t           state;
    draw_state_t           state_next;
    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  draw_sel;
    logic                  addr_ok;
    logic                  swap;
    logic                  rd_sel;
    logic                  draw_en;
    logic                  draw_we;
    logic [ADDR_WIDTH-1:0] draw_addr;
    logic                  draw_wd;

    fb_clear_engine #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_clear (
        .clkRD(clkRD),
        .rst_n(rst_n),
        .start(clr_start),
        .busy (clr_busy),
        .done (clr_done),
        .addr (clr_addr)
    );

    assign draw_sel = (disp_sel == BUF0) ? BUF1 : BUF0;
    assign addr_ok  = {1'b0, wr_addr} < DEPTH_EXT;
    assign swap     = (state == DONE) && frame_start;
    assign wr_ready = (state == DRAW);

    always_ff @(posedge clkRD or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // wr_last wins over a coincident frame_start: the swap waits for the next frame.
    always_comb begin
        state_next = state;
        clr_start  = 1'b0;
        case (state)
            CLEAR: if (clr_done) state_next = DRAW;
            DRAW:  if (wr_req && wr_last) state_next = DONE;
            DONE: begin
                if (frame_start) begin
                    state_next = CLEAR;
                    clr_start  = 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clkRD or negedge rst_n) begin
        if (!rst_n) begin
            disp_sel    <= BUF0;
            frame_valid <= 1'b0;
            addr_err    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_sel      <= BUF0;
        end else begin
            if (swap) begin
                disp_sel    <= draw_sel;
                frame_valid <= 1'b1;
            end
            if ((state == DRAW) && wr_req && !addr_ok) begin
                addr_err <= 1'b1;
            end
            rd_valid <= rd_en;
            rd_sel   <= disp_sel;
        end
    end

    always_comb begin
        draw_en   = 1'b0;
        draw_we   = 1'b0;
        draw_addr = clr_addr;
        draw_wd   = 1'b0;
        case (state)
            CLEAR: begin
                draw_en = clr_busy;
                draw_we = clr_busy;
            end
            DRAW: begin
                if (wr_req && addr_ok) begin
                    draw_en   = 1'b1;
                    draw_we   = 1'b1;
                    draw_addr = wr_addr;
                    draw_wd   = wr_data;
                end
            end
            default: ;
        endcase
    end

    // Reset gates the enables combinationally so a BRAM never sees a stray write while rst_n is low.
    always_comb begin
        if (draw_sel == BUF0) begin
            EN0    = draw_en;
            WE0    = draw_we;
            addrB0 = draw_addr;
            EN1    = rd_en;
            WE1    = 1'b0;
            addrB1 = rd_addr;
        end else begin
            EN0    = rd_en;
            WE0    = 1'b0;
            addrB0 = rd_addr;
            EN1    = draw_en;
            WE1    = draw_we;
            addrB1 = draw_addr;
        end
        if (!rst_n) begin
            EN0 = 1'b0;
            WE0 = 1'b0;
            EN1 = 1'b0;
            WE1 = 1'b0;
        end
    end

    assign WD      = draw_wd;
    assign rd_data = rd_valid && frame_valid && ((rd_sel == BUF1) ? RD1 : RD0);

endmodule

// File: tb/tb_fb_pingpong_arbiter.sv
// Directed bench for fb_pingpong_arbiter with DEPTH=16 and behavioural negedge BRAMs.
// Read expectations are queued at issue time and matched by an independent rd_valid monitor.
module tb_fb_pingpong_arbiter;

    localparam int AW    = 19;
    localparam int DEPTH = 16;

    logic          clkRD = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          rd_valid;
    logic          EN0, WE0, EN1, WE1, WD;
    logic [AW-1:0] addrB0, addrB1;
    logic          RD0 = 1'b0;
    logic          RD1 = 1'b0;
    logic          disp_sel;
    logic          frame_valid;
    logic          addr_err;

    logic mem0 [0:31];
    logic mem1 [0:31];
    logic expQ [$];

    int assertions = 0;
    int failures   = 0;

    always #5 clkRD = ~clkRD;

    fb_pingpong_arbiter #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clkRD(clkRD), .rst_n(rst_n), .frame_start(frame_start),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .EN0(EN0), .WE0(WE0), .addrB0(addrB0),
        .EN1(EN1), .WE1(WE1), .addrB1(addrB1), .WD(WD), .RD0(RD0), .RD1(RD1),
        .disp_sel(disp_sel), .frame_valid(frame_valid), .addr_err(addr_err)
    );

    // Both buffers start full of 1s so a missing clear is visible on readback.
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 1'b1;
            mem1[i] = 1'b1;
        end
    end

    always @(negedge clkRD) begin
        if (EN0) begin
            if (WE0) mem0[addrB0[4:0]] <= WD;
            else     RD0 <= mem0[addrB0[4:0]];
        end
        if (EN1) begin
            if (WE1) mem1[addrB1[4:0]] <= WD;
            else     RD1 <= mem1[addrB1[4:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(posedge clkRD) begin
        #2;
        if (rd_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                checkOutput("rd_data", 32'(rd_data), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic nextCycle();
        @(posedge clkRD);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic req, input int addr, input logic data,
                                 input logic last, input logic ren, input int raddr, input logic expRd);
        frame_start = fs;
        wr_req      = req;
        wr_addr     = AW'(addr);
        wr_data     = data;
        wr_last     = last;
        rd_en       = ren;
        rd_addr     = AW'(raddr);
        if (ren) expQ.push_back(expRd);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        idle();
        repeat (2) nextCycle();
        checkOutput("reset_enables", 32'({EN0, WE0, EN1, WE1}), 32'd0);
        checkOutput("reset_flags", 32'({wr_ready, disp_sel, frame_valid, addr_err, rd_valid, rd_data}), 32'd0);

        rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0) begin
                nextCycle();
                #1;
            end
            checkOutput($sformatf("clear1_c%0d", k),
                        32'({EN0, EN1, WE1, addrB1[4:0], WD, wr_ready}),
                        32'({1'b0, 1'b1, 1'b1, 5'(k), 1'b0, 1'b0}));
        end
        nextCycle();
        #1;
        checkOutput("wr_ready_cycle16", 32'(wr_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);

        nextCycle();
        applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("wr3", 32'({EN1, WE1, addrB1[4:0], WD}), 32'({1'b1, 1'b1, 5'd3, 1'b1}));
        nextCycle();
        applyStimulus(1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("fs_in_draw_ignored", 32'(disp_sel), 32'd0);
        checkOutput("wr20_dropped", 32'({EN0, WE0, EN1, WE1}), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("addr_err_set", 32'(addr_err), 32'd1);
        checkOutput("wr7", 32'({EN1, WE1, addrB1[4:0], WD}), 32'({1'b1, 1'b1, 5'd7, 1'b1}));
        nextCycle();
        applyStimulus(1'b1, 1'b1, 15, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        checkOutput("wr15_last", 32'({EN1, WE1, addrB1[4:0], WD}), 32'({1'b1, 1'b1, 5'd15, 1'b1}));
        nextCycle();
        idle();
        checkOutput("done_idle", 32'({wr_ready, EN1, WE1, disp_sel, frame_valid, addr_err}),
                    32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b1);
        checkOutput("swap_cycle_read_old", 32'({EN0, WE0}), 32'({1'b1, 1'b0}));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b1);
        checkOutput("swap1", 32'({disp_sel, frame_valid, wr_ready}), 32'({1'b1, 1'b1, 1'b0}));
        checkOutput("clear0_start", 32'({EN0, WE0, addrB0[4:0], WD}), 32'({1'b1, 1'b1, 5'd0, 1'b0}));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 15, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
        nextCycle();
        idle();

        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            nextCycle();
            #1;
            seen = wr_ready;
        end
        checkOutput("clear0_done", 32'(seen), 32'd1);

        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        checkOutput("fs_in_draw2_ignored", 32'(disp_sel), 32'd1);
        checkOutput("wr2_bram0", 32'({EN0, WE0, addrB0[4:0], WD, EN1}), 32'({1'b1, 1'b1, 5'd2, 1'b1, 1'b0}));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        checkOutput("swap2", 32'(disp_sel), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        idle();
        checkOutput("clear1b_progress", 32'({WE1, addrB1[4:0]}), 32'({1'b1, 5'd3}));

        rst_n = 1'b0;
        #1;
        checkOutput("midclear_reset_enables", 32'({EN0, WE0, EN1, WE1}), 32'd0);
        checkOutput("midclear_reset_flags", 32'({disp_sel, frame_valid, addr_err, wr_ready}), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("clear_restart0", 32'({EN1, WE1, addrB1[4:0], EN0}), 32'({1'b1, 1'b1, 5'd0, 1'b0}));
        nextCycle();
        #1;
        checkOutput("clear_restart1", 32'({WE1, addrB1[4:0]}), 32'({1'b1, 5'd1}));

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
